// File: rtl/semaforo_pkg.sv
// Shared state codes, fault codes and decode helpers for the traffic-light supervisor.
// The optional pedestrian WALK output is built only when SEMAFORO_WALK_EN is defined.
package semaforo_pkg;

  typedef logic [3:0] state_code_t;

  localparam state_code_t ST_OFF    = 4'b0001;
  localparam state_code_t ST_RED    = 4'b0010;
  localparam state_code_t ST_YELLOW = 4'b0100;
  localparam state_code_t ST_GREEN  = 4'b1000;

  typedef enum logic [2:0] {
    FLT_NONE          = 3'd0,
    FLT_ILLEGAL_STATE = 3'd1,
    FLT_LAMP_MISMATCH = 3'd2,
    FLT_TRANSITION    = 3'd3,
    FLT_OVERRUN       = 3'd4,
    FLT_UNDERRUN      = 3'd5
  } fault_code_t;

  // Lamp pattern {red, yellow, green} that a legal state code must present.
  function automatic logic [2:0] lamp_decode(input state_code_t s);
    case (s)
      ST_RED:    lamp_decode = 3'b100;
      ST_YELLOW: lamp_decode = 3'b010;
      ST_GREEN:  lamp_decode = 3'b001;
      default:   lamp_decode = 3'b000;
    endcase
  endfunction

  // Holding a state is always a legal step; dropping to OFF is legal from anywhere.
  function automatic logic legal_step(input state_code_t prev, input state_code_t next);
    legal_step = (prev == next) ||
                 (next == ST_OFF) ||
                 (prev == ST_OFF    && next == ST_RED) ||
                 (prev == ST_RED    && next == ST_YELLOW) ||
                 (prev == ST_YELLOW && next == ST_GREEN) ||
                 (prev == ST_GREEN  && next == ST_RED);
  endfunction

endpackage

// File: rtl/semaforo_if.sv
// Bundle between the traffic-light FSM (master) and the supervisor (slave).
interface semaforo_if;
  logic       red_in;
  logic       yellow_in;
  logic       green_in;
  logic [3:0] state_in;
  logic       clear_fault;
  logic       red_out;
  logic       yellow_out;
  logic       green_out;
  logic       walk;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output red_in, yellow_in, green_in, state_in, clear_fault,
    input  red_out, yellow_out, green_out, walk, fault, fault_code
  );

  modport slave (
    input  red_in, yellow_in, green_in, state_in, clear_fault,
    output red_out, yellow_out, green_out, walk, fault, fault_code
  );
endinterface

// File: rtl/semaforo_blinker.sv
// Safe-mode yellow blinker: restarts high on start, toggles every BLINK_HALF cycles while run.
module semaforo_blinker #(
  parameter int BLINK_HALF = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic blink
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (run) begin
      if (cnt == CW'(BLINK_HALF - 1)) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt   <= '0;
      blink <= 1'b0;
    end
  end

endmodule

// File: rtl/semaforo_supervisor.sv
// Traffic-light supervisor: checks state legality, transitions and dwell, latches the first fault
// and drives safe mode (blinking yellow). WALK lamp logic exists only with SEMAFORO_WALK_EN.
module semaforo_supervisor
  import semaforo_pkg::*;
#(
  parameter int RED_CYCLES    = 51,
  parameter int YELLOW_CYCLES = 11,
  parameter int GREEN_CYCLES  = 41,
  parameter int BLINK_HALF    = 25,
  parameter int CNT_W         = 8
`ifdef SEMAFORO_WALK_EN
  , parameter int WALK_CLEAR  = 8
`endif
) (
  input  logic      clk,
  input  logic      rst,
  semaforo_if.slave bus
);

  state_code_t      prev_state;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] dwell_next;
  logic [CNT_W-1:0] exp_prev;
  logic             changed;
  logic             timed_prev;
  logic             viol;
  fault_code_t      viol_code;
  logic             clear_ok;
  logic             fault;
  logic             fault_next;
  fault_code_t      fault_code;
  fault_code_t      fault_code_next;
  logic             blink_start;
  logic             blink;
  logic             red_q;
  logic             yellow_q;
  logic             green_q;

  // dwell holds how many cycles prev_state has been seen, so it lags state_in by one cycle.
  always_comb begin
    changed    = (bus.state_in != prev_state);
    timed_prev = (prev_state == ST_RED) || (prev_state == ST_YELLOW) || (prev_state == ST_GREEN);
    case (prev_state)
      ST_RED:    exp_prev = CNT_W'(RED_CYCLES);
      ST_YELLOW: exp_prev = CNT_W'(YELLOW_CYCLES);
      ST_GREEN:  exp_prev = CNT_W'(GREEN_CYCLES);
      default:   exp_prev = '1;
    endcase
    if (changed)
      dwell_next = CNT_W'(1);
    else if (&dwell)
      dwell_next = dwell;
    else
      dwell_next = dwell + CNT_W'(1);
  end

  always_comb begin
    viol      = 1'b1;
    viol_code = FLT_NONE;
    if (!$onehot(bus.state_in))
      viol_code = FLT_ILLEGAL_STATE;
    else if ({bus.red_in, bus.yellow_in, bus.green_in} != lamp_decode(bus.state_in))
      viol_code = FLT_LAMP_MISMATCH;
    else if (!legal_step(prev_state, bus.state_in))
      viol_code = FLT_TRANSITION;
    else if (!changed && timed_prev && dwell == exp_prev)
      viol_code = FLT_OVERRUN;
    else if (changed && timed_prev && bus.state_in != ST_OFF && dwell < exp_prev)
      viol_code = FLT_UNDERRUN;
    else
      viol = 1'b0;
  end

  // A violation in the clearing cycle re-arms the fault with the new cause.
  always_comb begin
    clear_ok        = bus.clear_fault && (bus.state_in == ST_OFF);
    fault_next      = fault;
    fault_code_next = fault_code;
    blink_start     = 1'b0;
    if (viol && (!fault || clear_ok)) begin
      fault_next      = 1'b1;
      fault_code_next = viol_code;
      blink_start     = 1'b1;
    end else if (clear_ok) begin
      fault_next      = 1'b0;
      fault_code_next = FLT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= ST_OFF;
      dwell      <= '0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      red_q      <= 1'b0;
      yellow_q   <= 1'b0;
      green_q    <= 1'b0;
    end else begin
      prev_state <= bus.state_in;
      dwell      <= dwell_next;
      fault      <= fault_next;
      fault_code <= fault_code_next;
      red_q      <= bus.red_in    && !fault_next;
      yellow_q   <= bus.yellow_in && !fault_next;
      green_q    <= bus.green_in  && !fault_next;
    end
  end

  semaforo_blinker #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blinker (
    .clk  (clk),
    .rst  (rst),
    .start(blink_start),
    .run  (fault_next),
    .blink(blink)
  );

  // yellow_q is forced low in safe mode and blink is low in normal mode, so the OR never overlaps.
  assign bus.red_out    = red_q;
  assign bus.yellow_out = yellow_q | blink;
  assign bus.green_out  = green_q;
  assign bus.fault      = fault;
  assign bus.fault_code = fault_code;

`ifdef SEMAFORO_WALK_EN
  logic walk_q;

  always_ff @(posedge clk) begin
    if (rst)
      walk_q <= 1'b0;
    else
      walk_q <= !fault_next && (bus.state_in == ST_RED) &&
                (dwell_next <= CNT_W'(RED_CYCLES - WALK_CLEAR));
  end

  assign bus.walk = walk_q;
`else
  assign bus.walk = 1'b0;
`endif

endmodule
